// File: rtl/simon_cipher_engine.sv
// -----------------------------------------------------------------------------
// simon_cipher_engine
//
// Iterative Simon block cipher. One round per clock, with the round function,
// the key schedule and a decryption-key register bank in a single datapath.
// A small FSM sequences load, key expansion, rounds and result hand-off.
//
// Decryption runs the key schedule forward to the last round keys, stores
// them in the bank, reloads the key window from the bank and then walks the
// schedule backwards while applying the encryption round to the word-swapped
// block. The swap makes the inverse round identical to the forward one.
//
// Parameters
//   WW        word size n (16, 24, 32, 48, 64)
//   NKW       key words m (16/4, 24/{3,4}, 32/{3,4}, 48/{2,3}, 64/{2,3,4})
//   DATA_RST  1: block, key window, key bank and ct_o are cleared by reset
//
// Ports
//   clk       clock, rising edge
//   arst_n    reset, synchronous, active-low
//   active_o  high whenever the FSM is not in IDLE
//   valid_i   input block valid
//   ready_o   input accepted when valid_i & ready_o (from state only)
//   mode_i    0 = encrypt, 1 = decrypt; sampled at the input handshake
//   pt_i      input block, [2WW-1:WW] = x, [WW-1:0] = y
//   key_i     key, word i = k_i (word 0 is the first round key)
//   valid_o   ct_o holds a finished result
//   ready_i   result consumed when valid_o & ready_i
//   mode_o    mode of the result on ct_o
//   ct_o      result block, same word order as pt_i
// -----------------------------------------------------------------------------
module simon_cipher_engine #(
    parameter int WW       = 32,
    parameter int NKW      = 4,
    parameter bit DATA_RST = 1'b0
) (
    input  logic              clk,
    input  logic              arst_n,
    output logic              active_o,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              mode_i,
    input  logic [2*WW-1:0]   pt_i,
    input  logic [NKW*WW-1:0] key_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              mode_o,
    output logic [2*WW-1:0]   ct_o
);

    // Published Simon constant sequences; leftmost bit is z_j[0].
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    function automatic int calc_rounds(input int ww, input int nkw);
        case (ww)
            16:      return 32;
            24:      return 36;
            32:      return (nkw == 3) ? 42 : 44;
            48:      return (nkw == 2) ? 52 : 54;
            default: return (nkw == 2) ? 68 : ((nkw == 3) ? 69 : 72);
        endcase
    endfunction

    function automatic logic [61:0] calc_z(input int ww, input int nkw);
        case (ww)
            16:      return Z0;
            24:      return (nkw == 3) ? Z0 : Z1;
            32:      return (nkw == 3) ? Z2 : Z3;
            48:      return (nkw == 2) ? Z2 : Z3;
            default: return (nkw == 2) ? Z2 : ((nkw == 3) ? Z3 : Z4);
        endcase
    endfunction

    localparam int          T           = calc_rounds(WW, NKW);
    localparam logic [61:0] Z_SEQ       = calc_z(WW, NKW);
    localparam logic [6:0]  LAST_ROUND  = 7'(T - 1);
    localparam logic [6:0]  KEXP_STEPS  = 7'(T - NKW);      // cycle index of the reload
    localparam logic [6:0]  KEXP_LAST   = 7'(T - NKW - 1);  // last forward step
    // Decryption first recovers k_{T-NKW-1}, so the z index starts there.
    localparam logic [5:0]  Z_DEC_START = 6'((T - NKW - 1) % 62);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_KEXP,
        S_DEC,
        S_FIN,
        S_DONE
    } state_t;

    function automatic logic [WW-1:0] rotl(input logic [WW-1:0] v, input int s);
        return (v << s) | (v >> (WW - s));
    endfunction

    function automatic logic [WW-1:0] rotr(input logic [WW-1:0] v, input int s);
        return (v >> s) | (v << (WW - s));
    endfunction

    function automatic logic [WW-1:0] f_round(input logic [WW-1:0] x);
        return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
    endfunction

    // Control state
    state_t     state;
    logic [6:0] rnd;       // cycle counter within ENC / KEXP / DEC
    logic [5:0] zi;        // current index into Z_SEQ (mod 62)
    logic       mode_q;    // mode captured at the handshake

    // Datapath state
    logic [WW-1:0] blk_x;
    logic [WW-1:0] blk_y;
    logic [WW-1:0] kwin  [NKW];  // kwin[0] = oldest key of the window
    logic [WW-1:0] kbank [NKW];

    // Combinational datapath
    logic          z_bit;
    logic [WW-1:0] z_const;
    logic [WW-1:0] rnd_key;
    logic [WW-1:0] new_x;
    logic [WW-1:0] tmp_fwd;
    logic [WW-1:0] tmp_inv;
    logic [WW-1:0] k_fwd;
    logic [WW-1:0] k_inv;
    logic [5:0]    zi_inc;
    logic [5:0]    zi_dec;

    assign ready_o  = (state == S_IDLE);
    assign active_o = (state != S_IDLE);

    assign zi_inc = (zi == 6'd61) ? 6'd0  : zi + 6'd1;
    assign zi_dec = (zi == 6'd0)  ? 6'd61 : zi - 6'd1;

    assign z_bit   = Z_SEQ[6'd61 - zi];
    // ~k ^ tmp ^ z ^ 3 is the published c ^ z ^ k ^ tmp with c = ~3.
    assign z_const = WW'(3) ^ WW'(z_bit);

    // Decryption consumes the newest window key, encryption the oldest.
    assign rnd_key = (state == S_DEC) ? kwin[NKW-1] : kwin[0];
    assign new_x   = blk_y ^ f_round(blk_x) ^ rnd_key;

    always_comb begin
        // NOTE: each variable here is assigned unconditionally before any
        // conditional update, so no latch can be inferred.
        tmp_fwd = rotr(kwin[NKW-1], 3);
        if (NKW == 4) tmp_fwd = tmp_fwd ^ kwin[1];
        tmp_fwd = tmp_fwd ^ rotr(tmp_fwd, 1);
        k_fwd   = ~kwin[0] ^ tmp_fwd ^ z_const;

        // Window holds k_{j+1}..k_{j+NKW}; solve the forward step for k_j.
        tmp_inv = rotr(kwin[NKW-2], 3);
        if (NKW == 4) tmp_inv = tmp_inv ^ kwin[0];
        tmp_inv = tmp_inv ^ rotr(tmp_inv, 1);
        k_inv   = ~kwin[NKW-1] ^ tmp_inv ^ z_const;
    end

    // Control FSM with registered result flags
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!arst_n) begin
            state   <= S_IDLE;
            rnd     <= '0;
            zi      <= '0;
            mode_q  <= 1'b0;
            valid_o <= 1'b0;
            mode_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        mode_q <= mode_i;
                        rnd    <= '0;
                        zi     <= '0;
                        state  <= mode_i ? S_KEXP : S_ENC;
                    end
                end
                S_ENC: begin
                    rnd <= rnd + 7'd1;
                    zi  <= zi_inc;
                    if (rnd == LAST_ROUND) state <= S_FIN;
                end
                S_KEXP: begin
                    if (rnd == KEXP_STEPS) begin
                        rnd   <= '0;
                        zi    <= Z_DEC_START;
                        state <= S_DEC;
                    end else begin
                        rnd <= rnd + 7'd1;
                        zi  <= zi_inc;
                    end
                end
                S_DEC: begin
                    rnd <= rnd + 7'd1;
                    zi  <= zi_dec;
                    if (rnd == LAST_ROUND) state <= S_FIN;
                end
                S_FIN: begin
                    valid_o <= 1'b1;
                    mode_o  <= mode_q;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        // NOTE: data registers are only cleared when DATA_RST is set; the
        // control path alone guarantees nothing stale is ever presented.
        if (DATA_RST && !arst_n) begin
            blk_x <= '0;
            blk_y <= '0;
            ct_o  <= '0;
            for (int i = 0; i < NKW; i++) begin
                kwin[i]  <= '0;
                kbank[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        for (int i = 0; i < NKW; i++) kwin[i] <= key_i[i*WW +: WW];
                        // Block is captured at the handshake; key expansion
                        // leaves it untouched. Decryption works on swapped words.
                        if (mode_i) begin
                            blk_x <= pt_i[WW-1:0];
                            blk_y <= pt_i[2*WW-1:WW];
                        end else begin
                            blk_x <= pt_i[2*WW-1:WW];
                            blk_y <= pt_i[WW-1:0];
                        end
                    end
                end
                S_ENC: begin
                    blk_x <= new_x;
                    blk_y <= blk_x;
                    for (int i = 0; i < NKW - 1; i++) kwin[i] <= kwin[i+1];
                    kwin[NKW-1] <= k_fwd;
                end
                S_KEXP: begin
                    if (rnd == KEXP_STEPS) begin
                        for (int i = 0; i < NKW; i++) kwin[i] <= kbank[i];
                    end else begin
                        for (int i = 0; i < NKW - 1; i++) kwin[i] <= kwin[i+1];
                        kwin[NKW-1] <= k_fwd;
                        if (rnd == KEXP_LAST) begin
                            for (int i = 0; i < NKW - 1; i++) kbank[i] <= kwin[i+1];
                            kbank[NKW-1] <= k_fwd;
                        end
                    end
                end
                S_DEC: begin
                    blk_x <= new_x;
                    blk_y <= blk_x;
                    for (int i = 1; i < NKW; i++) kwin[i] <= kwin[i-1];
                    kwin[0] <= k_inv;
                end
                S_FIN: begin
                    ct_o <= mode_q ? {blk_y, blk_x} : {blk_x, blk_y};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_cipher_engine.sv
// -----------------------------------------------------------------------------
// tb_simon_cipher_engine
//
// Directed bench for simon_cipher_engine. Two instances: Simon64/128
// (defaults, DATA_RST = 0) and Simon32/64 (WW = 16, NKW = 4, DATA_RST = 1).
// Expected values are the published test vectors and the fixed latencies
// T+1 (encrypt) and 2T-NKW+2 (decrypt).
// -----------------------------------------------------------------------------
module tb_simon_cipher_engine;

    localparam logic [127:0] KEY    = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  PT     = 64'h656b696c_20646e75;
    localparam logic [63:0]  CT     = 64'h44c8fc20_b9dfa07a;
    localparam int           ENC_LAT = 45;   // T = 44
    localparam int           DEC_LAT = 86;   // 2*44 - 4 + 2

    localparam logic [63:0]  S_KEY  = 64'h1918_1110_0908_0100;
    localparam logic [31:0]  S_PT   = 32'h6565_6877;
    localparam logic [31:0]  S_CT   = 32'hc69b_e9bb;
    localparam int           S_ENC_LAT = 33; // T = 32
    localparam int           S_DEC_LAT = 62; // 2*32 - 4 + 2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n;

    // Simon64/128 instance
    logic         valid_i, ready_o, mode_i, valid_o, ready_i, mode_o, active_o;
    logic [63:0]  pt_i, ct_o;
    logic [127:0] key_i;

    // Simon32/64 instance
    logic         s_valid_i, s_ready_o, s_mode_i, s_valid_o, s_ready_i, s_mode_o, s_active_o;
    logic [31:0]  s_pt_i, s_ct_o;
    logic [63:0]  s_key_i;

    int checks = 0;
    int errors = 0;
    int lat;

    simon_cipher_engine dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .active_o (active_o),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .mode_i   (mode_i),
        .pt_i     (pt_i),
        .key_i    (key_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .mode_o   (mode_o),
        .ct_o     (ct_o)
    );

    simon_cipher_engine #(.WW(16), .NKW(4), .DATA_RST(1'b1)) dut_s (
        .clk      (clk),
        .arst_n   (arst_n),
        .active_o (s_active_o),
        .valid_i  (s_valid_i),
        .ready_o  (s_ready_o),
        .mode_i   (s_mode_i),
        .pt_i     (s_pt_i),
        .key_i    (s_key_i),
        .valid_o  (s_valid_o),
        .ready_i  (s_ready_i),
        .mode_o   (s_mode_o),
        .ct_o     (s_ct_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one block to the 64/128 instance; returns #1 after the accepting edge.
    task automatic start_op(input logic m, input logic [63:0] pt, input string tag);
        @(negedge clk);
        check({tag, " ready_o idle"}, 128'(ready_o), 128'(1'b1));
        valid_i = 1'b1;
        mode_i  = m;
        pt_i    = pt;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check({tag, " ready_o busy"}, 128'(ready_o), 128'(1'b0));
        check({tag, " active_o busy"}, 128'(active_o), 128'(1'b1));
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (valid_o !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic s_start_op(input logic m, input logic [31:0] pt);
        @(negedge clk);
        check("s ready_o idle", 128'(s_ready_o), 128'(1'b1));
        s_valid_i = 1'b1;
        s_mode_i  = m;
        s_pt_i    = pt;
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
    endtask

    task automatic s_wait_result(output int n);
        n = 0;
        while (s_valid_o !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        arst_n    = 1'b0;
        valid_i   = 1'b0;
        mode_i    = 1'b0;
        pt_i      = '0;
        key_i     = KEY;
        ready_i   = 1'b0;
        s_valid_i = 1'b0;
        s_mode_i  = 1'b0;
        s_pt_i    = '0;
        s_key_i   = S_KEY;
        s_ready_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready_o",    128'(ready_o),    128'(1'b1));
        check("rst valid_o",    128'(valid_o),    128'(1'b0));
        check("rst active_o",   128'(active_o),   128'(1'b0));
        check("rst mode_o",     128'(mode_o),     128'(1'b0));
        check("rst s_valid_o",  128'(s_valid_o),  128'(1'b0));
        check("rst s_ct_o",     128'(s_ct_o),     128'(32'h0));
        arst_n = 1'b1;

        // Encrypt 64/128 with output backpressure
        start_op(1'b0, PT, "enc");
        wait_result(lat);
        check("enc latency", 128'(lat),    128'(ENC_LAT));
        check("enc ct",      128'(ct_o),   128'(CT));
        check("enc mode_o",  128'(mode_o), 128'(1'b0));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("hold valid_o",  128'(valid_o),  128'(1'b1));
            check("hold ct_o",     128'(ct_o),     128'(CT));
            check("hold ready_o",  128'(ready_o),  128'(1'b0));
            check("hold active_o", 128'(active_o), 128'(1'b1));
        end
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("release valid_o",  128'(valid_o),  128'(1'b0));
        check("release ready_o",  128'(ready_o),  128'(1'b1));
        check("release active_o", 128'(active_o), 128'(1'b0));

        // Decrypt 64/128
        start_op(1'b1, CT, "dec");
        wait_result(lat);
        check("dec latency", 128'(lat),    128'(DEC_LAT));
        check("dec pt",      128'(ct_o),   128'(PT));
        check("dec mode_o",  128'(mode_o), 128'(1'b1));
        @(posedge clk);
        #1;
        check("dec after-done ready_o", 128'(ready_o), 128'(1'b1));
        check("dec after-done valid_o", 128'(valid_o), 128'(1'b0));

        // Reset in the middle of encryption
        start_op(1'b0, PT, "abort");
        repeat (10) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort valid_o",  128'(valid_o),  128'(1'b0));
        check("abort active_o", 128'(active_o), 128'(1'b0));
        check("abort ready_o",  128'(ready_o),  128'(1'b1));
        @(negedge clk);
        arst_n = 1'b1;

        // Back-to-back: fresh encrypt, then decrypt of its result
        start_op(1'b0, PT, "b2b enc");
        wait_result(lat);
        check("b2b enc latency", 128'(lat),  128'(ENC_LAT));
        check("b2b enc ct",      128'(ct_o), 128'(CT));
        @(posedge clk);
        #1;
        check("b2b enc after-done ready_o", 128'(ready_o), 128'(1'b1));
        start_op(1'b1, CT, "b2b dec");
        wait_result(lat);
        check("b2b dec latency", 128'(lat),    128'(DEC_LAT));
        check("b2b dec pt",      128'(ct_o),   128'(PT));
        check("b2b dec mode_o",  128'(mode_o), 128'(1'b1));
        @(posedge clk);
        #1;
        check("b2b dec after-done ready_o", 128'(ready_o), 128'(1'b1));

        // Simon32/64
        s_start_op(1'b0, S_PT);
        check("s enc active_o", 128'(s_active_o), 128'(1'b1));
        s_wait_result(lat);
        check("s enc latency", 128'(lat),      128'(S_ENC_LAT));
        check("s enc ct",      128'(s_ct_o),   128'(S_CT));
        check("s enc mode_o",  128'(s_mode_o), 128'(1'b0));
        @(posedge clk);
        #1;
        check("s enc after-done ready_o", 128'(s_ready_o), 128'(1'b1));
        s_start_op(1'b1, S_CT);
        s_wait_result(lat);
        check("s dec latency", 128'(lat),      128'(S_DEC_LAT));
        check("s dec pt",      128'(s_ct_o),   128'(S_PT));
        check("s dec mode_o",  128'(s_mode_o), 128'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
